// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   - uart_tx_state_t: transmitter state encoding (IDLE, START, DATA, PARITY, STOP)
//   - UART_DATA_BITS / UART_FRAME_BITS: frame geometry (1 start, 8 data, 1 parity, 1 stop)
//   - baud_clocks(): system clocks per bit period, integer-truncated
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 11;

    // Plain constants rather than an enum so older tools and rx can share the encoding.
    typedef logic [2:0] uart_tx_state_t;
    localparam uart_tx_state_t IDLE   = 3'd0;
    localparam uart_tx_state_t START  = 3'd1;
    localparam uart_tx_state_t DATA   = 3'd2;
    localparam uart_tx_state_t PARITY = 3'd3;
    localparam uart_tx_state_t STOP   = 3'd4;

    function automatic int unsigned baud_clocks(input int unsigned clk_hz,
                                                input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the UART transmitter and receiver.
// Counts 0..BAUD_CLOCKS-1 and wraps; tick is high for the single cycle at the last count.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   clear - synchronous clear, holds the count at 0 while asserted
//   tick  - bit-end strobe (count == BAUD_CLOCKS-1)
module uart_baud_gen #(
    parameter int unsigned BAUD_CLOCKS = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(BAUD_CLOCKS);

    if (BAUD_CLOCKS < 2) begin : g_bad_baud
        $error("uart_baud_gen: BAUD_CLOCKS must be at least 2");
    end

    localparam logic [CW-1:0] LAST = CW'(BAUD_CLOCKS - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear || (count_q == LAST)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per request.
// Frame: start (0), 8 data bits LSB first, parity, stop (1); each bit BAUD_CLOCKS cycles.
// Optional build macro UART_TX_TWO_STOP_EN: stop bit lasts two bit periods (12-bit frame).
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   din    - byte to send, sampled only on the accept cycle
//   send   - level-sensitive transmit request, accepted only in IDLE
//   tx_out - registered serial line, idle high
//   busy   - registered, high from the accept edge to the end of the stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE     = 19200,
    parameter bit          PARITY_ODD    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       send,
    output logic       tx_out,
    output logic       busy
);

    localparam int unsigned BAUD_CLOCKS = baud_clocks(CLK_FREQUENCY, BAUD_RATE);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic           parity_q, parity_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           tick;
`ifdef UART_TX_TWO_STOP_EN
    logic           stop2_q, stop2_d;
`endif

    // The counter idles at 0 so the start bit gets a full period from the accept edge.
    uart_baud_gen #(
        .BAUD_CLOCKS(BAUD_CLOCKS)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // Outputs are registered, so each branch sets tx_d to the level of the bit being entered.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d  = stop2_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    state_d  = START;
                    shift_d  = din;
                    parity_d = PARITY_ODD ? ~^din : ^din;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        stop2_d = 1'b0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= stop2_d;
`endif
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Runs an odd-parity and an even-parity instance side by side at 10 clocks per bit.
// A frame-level model predicts tx_out/busy every cycle; directed tests add literal checks.
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned B      = CLK_HZ / BAUD;
`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned NSTOP     = 2;
    localparam int unsigned BUSY_LIT  = 120;
`else
    localparam int unsigned NSTOP     = 1;
    localparam int unsigned BUSY_LIT  = 110;
`endif
    localparam int unsigned FRAME = (10 + NSTOP) * B;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] din  = 8'h00;
    logic       send = 1'b0;
    logic       tx_odd, busy_odd, tx_even, busy_even;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQUENCY(CLK_HZ),
        .BAUD_RATE    (BAUD),
        .PARITY_ODD   (1'b1)
    ) dut_odd (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .send  (send),
        .tx_out(tx_odd),
        .busy  (busy_odd)
    );

    uart_tx #(
        .CLK_FREQUENCY(CLK_HZ),
        .BAUD_RATE    (BAUD),
        .PARITY_ODD   (1'b0)
    ) dut_even (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .send  (send),
        .tx_out(tx_even),
        .busy  (busy_even)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is an 11-bit vector, each bit shown for B cycles.
    bit          m_act = 1'b0;
    int          m_pos = 0;
    logic [10:0] m_fo  = '1;
    logic [10:0] m_fe  = '1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (send) begin
                m_act = 1'b1;
                m_pos = 0;
                m_fo  = {1'b1, ~^din, din, 1'b0};
                m_fe  = {1'b1, ^din, din, 1'b0};
            end
        end else begin
            m_pos++;
            if (m_pos == int'(FRAME)) m_act = 1'b0;
        end
    end

    function automatic logic exp_tx(input logic [10:0] fr);
        int k;
        if (!m_act) return 1'b1;
        k = m_pos / int'(B);
        if (k > 10) k = 10;
        return fr[k];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_tx_odd", tx_odd, exp_tx(m_fo));
            check("model_busy_odd", busy_odd, m_act);
            check("model_tx_even", tx_even, exp_tx(m_fe));
            check("model_busy_even", busy_even, m_act);
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_odd || busy_even) && n < int'(2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        check(name, busy_odd, 1'b0);
    endtask

    // Sends one byte, samples both lines at each mid-bit point, then waits for idle.
    // With ovl set, a second request is raised mid-frame and must be ignored.
    task automatic send_capture(input logic [7:0] d, input bit ovl,
                                output logic [10:0] bo, output logic [10:0] be);
        @(negedge clk);
        din  = d;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (B / 2) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            bo[k] = tx_odd;
            be[k] = tx_even;
            if (ovl && k == 3) begin
                din  = 8'h3C;
                send = 1'b1;
            end
            if (ovl && k == 8) begin
                send = 1'b0;
                din  = 8'h00;
            end
            if (k < 10) repeat (B) @(negedge clk);
        end
        wait_idle("frame_end");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bo, be;
        logic [7:0]  r;
        int          n;
        logic        prev;

        // Reset
        #80;
        @(negedge clk);
        rst = 1'b1;
        check("reset_tx", tx_odd, 1'b1);
        check("reset_busy", busy_odd, 1'b0);
        cmp_en = 1'b1;
        n = 0;
        prev = tx_odd;
        repeat (1000) begin
            @(negedge clk);
            if (tx_odd !== prev) n++;
            prev = tx_odd;
        end
        check("idle_no_transitions", n, 0);

        // 0x55: busy length, then mid-bit samples
        @(negedge clk);
        din  = 8'h55;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n = 0;
        while (busy_odd && n < int'(3 * FRAME)) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles_55", n, BUSY_LIT);
        @(negedge clk);
        send_capture(8'h55, 1'b0, bo, be);
        check("bits_55", bo, 11'b1_1_01010101_0);

        // Parity edge cases
        send_capture(8'h00, 1'b0, bo, be);
        check("parity_odd_00", bo[9], 1'b1);
        send_capture(8'hFF, 1'b0, bo, be);
        check("parity_odd_ff", bo[9], 1'b1);
        send_capture(8'h01, 1'b0, bo, be);
        check("parity_odd_01", bo[9], 1'b0);
        check("parity_even_01", be[9], 1'b1);

        // Overlapping request while busy is ignored
        send_capture(8'hA3, 1'b1, bo, be);
        check("overlap_bits", bo, 11'b1_1_10100011_0);
        repeat (3) @(negedge clk);
        check("overlap_no_second", busy_odd, 1'b0);

        // send held high: back-to-back frames with one idle cycle
        @(negedge clk);
        din  = 8'h5A;
        send = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy_odd && n < int'(2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!busy_odd && n < 10) begin
            check("gap_line_high", tx_odd, 1'b1);
            @(negedge clk);
            n++;
        end
        check("gap_len", n, 1);
        send = 1'b0;
        wait_idle("hold_end");

        // Reset during data bit 4 is immediate
        @(negedge clk);
        din  = 8'hC6;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5 * B + B / 2) @(negedge clk);
        check("pre_reset_busy", busy_odd, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_tx", tx_odd, 1'b1);
        check("async_reset_busy", busy_odd, 1'b0);
        check("async_reset_busy_even", busy_even, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        send_capture(8'h81, 1'b0, bo, be);
        check("after_reset_81", bo, 11'b1_1_10000001_0);

        // Random bytes with random gaps, decoded from the line
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom_range(0, 255));
            send_capture(r, 1'b0, bo, be);
            check("rand_data", bo[8:1], r);
            check("rand_start_stop", {bo[10], bo[0]}, 2'b10);
            check("rand_parity_even", be[9], ^r);
            repeat ($urandom_range(100, 200)) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serializes one byte per request onto a single line, at a fixed baud rate derived from the system clock. The frame is 1 start bit (0), 8 data bits LSB first, 1 parity bit, and 1 stop bit (1), for 11 bit periods total. It is the sending end for the existing rx receiver. It replaces tx_model as the synthesizable source in board-level loopback.

Parameters:
CLK_FREQUENCY, 100000000, system clock frequency in Hz.
BAUD_RATE, 19200, line bit rate in bits/s; BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE, integer-truncated (5208 at defaults).
PARITY_ODD, 1, 1 = odd parity (matches rx); 0 = even parity.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
din  input  8  byte to transmit; sampled only on the accept cycle.
send  input  1  transmit request, level-sensitive.
tx_out  output  1  serial line; idle high.
busy  output  1  high from the accept cycle through the end of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous) forces: tx_out=1, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, accept: on a clock edge where state=IDLE and send=1:
  - latch din into the shift register;
  - compute parity: odd = ~^din, even = ^din;
  - go to START; busy=1 from the next cycle.
- Latency: tx_out falls 1 cycle after the accept edge. tx_out and busy are registered outputs.
- Bit timing: each state holds for exactly BAUD_CLOCKS cycles. The baud counter runs 0..BAUD_CLOCKS-1 and clears on each state/bit change; the last count is the bit-end tick.
- START: tx_out=0. At the tick, go to DATA with bit index 0.
- DATA: tx_out = shift[0]. At each tick, shift right and increment the index. After index 7's tick, go to PARITY.
- PARITY: tx_out = latched parity bit. At the tick, go to STOP.
- STOP: tx_out=1. At the tick, go to IDLE and set busy=0.
- Frame length, accept edge to return to IDLE: 11*BAUD_CLOCKS cycles.
- send while busy=1 is ignored, and din changes mid-frame have no effect.
- If send is still 1 when IDLE is re-entered, a new frame is accepted on the next edge. IDLE therefore always lasts at least 1 cycle, with busy=0 for at least 1 cycle between frames.
- The baud counter width is $clog2(BAUD_CLOCKS). BAUD_CLOCKS < 2 is illegal; the block issues an elaboration-time $error.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: the STOP state lasts 2*BAUD_CLOCKS cycles (two stop bits). The frame is 12*BAUD_CLOCKS cycles, and busy stays high throughout.
- Undefined: one stop bit, 11*BAUD_CLOCKS frame.
- rx accepts either form, since the extra stop bit looks like idle line.

Decomposition:
- uart_pkg:
  - state enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_BITS=8;
  - UART_FRAME_BITS=11;
  - function baud_clocks(clk_hz, baud) shared with rx.
- One sub-module, uart_baud_gen:
  - parameterized counter with clear input and a one-cycle tick output at count BAUD_CLOCKS-1;
  - reusable by rx.

Test Plan:
- Reset: hold rst=0 for 80 ns, release on negedge clk → tx_out=1, busy=0; no transitions for 10 us.
- Byte 0x55, defaults (BAUD_CLOCKS=5208):
  - line samples at the mid-bit points are 0,1,0,1,0,1,0,1,0 (start + data LSB first), then parity 1 (odd over four 1s), then stop 1;
  - busy high for exactly 57288 cycles.
- Parity edge cases: 0x00 → parity bit 1; 0xFF → parity bit 1; 0x01 → parity bit 0. Rebuild with PARITY_ODD=0: 0x01 → parity bit 1.
- Overlap and hold: pulse send with 0xA3, then assert send with 0x3C while busy → only 0xA3 is transmitted. Holding send high continuously → back-to-back frames separated by exactly 1 idle cycle at tx_out=1.
- Reset mid-frame: assert rst=0 during DATA bit 4 → tx_out=1 and busy=0 within the same cycle (asynchronous). The next send of 0x81 is a clean frame.
- Loopback into rx:
  - 10 random bytes, random 100–200 cycle gaps → each data_strobe has dout equal to the sent byte and rx_error=0;
  - with UART_TX_TWO_STOP_EN defined, the frame is 12*5208 cycles and all bytes are still received correctly.
